// File: rtl/variables.sv
// Shared definitions for the integer back end.
//   cdb_bus        : common data bus broadcast record driven by int_exec_unit.
//   int_iq_entry_t : one reservation slot of int_issue_queue.
//   TAG_W, XLEN    : tag and datapath widths shared by every consumer of cdb_bus.
//   Opcode constants for the RV32I major opcodes.
package variables;

  localparam int TAG_W = 6;
  localparam int XLEN  = 32;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef struct packed {
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             cdb_branch;
  } cdb_bus;

  typedef struct packed {
    logic             valid;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             rdy1;
    logic [TAG_W-1:0] tag1;
    logic [XLEN-1:0]  val1;
    logic             rdy2;
    logic [TAG_W-1:0] tag2;
    logic [XLEN-1:0]  val2;
    logic [TAG_W-1:0] rd_tag;
  } int_iq_entry_t;

endpackage

// File: rtl/operand_capture.sv
// Combinational CDB snoop for a single source operand.
//   i_rdy/i_tag/i_val : current operand state (value valid when i_rdy=1).
//   i_cdb             : broadcast bus; only valid, tag and data matter.
//   o_rdy/o_val       : operand state after this cycle's broadcast.
module operand_capture
  import variables::*;
(
  input  logic             i_rdy,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [XLEN-1:0]  i_val,
  input  cdb_bus           i_cdb,
  output logic             o_rdy,
  output logic [XLEN-1:0]  o_val
);

  logic w_hit;
  logic w_unused;

  // A branch resolution without cdb_valid carries no result to capture.
  assign w_unused = i_cdb.cdb_branch;

  assign w_hit = ~i_rdy & i_cdb.cdb_valid & (i_tag == i_cdb.cdb_tag);
  assign o_rdy = i_rdy | w_hit;
  assign o_val = w_hit ? i_cdb.cdb_data : i_val;

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation queue between dispatch/rename and int_exec_unit.
// Age-ordered shifting storage (slot 0 oldest); operands wake from the CDB;
// the oldest fully-ready entry issues combinationally, one per cycle.
//   clk, rst_n (async, active-low), flush (sync clear)
//   dispatch_valid/dispatch_ready + disp_* : micro-op and operand state in
//   cdb_in                                 : result broadcast snooped for wakeup
//   issue_stall                            : consumer cannot take an op
//   issue_int, Opcode..RD_Tag              : issued micro-op (zero when idle)
// TAG_W and XLEN must equal the package constants of the same name.
module int_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = variables::TAG_W,
  parameter int XLEN  = variables::XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [6:0]       disp_opcode,
  input  logic [2:0]       disp_funct3,
  input  logic [6:0]       disp_funct7,
  input  logic [XLEN-1:0]  disp_rs1_data,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic             disp_rs1_rdy,
  input  logic [XLEN-1:0]  disp_rs2_data,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic             disp_rs2_rdy,
  input  logic [TAG_W-1:0] disp_rd_tag,
  input  variables::cdb_bus cdb_in,
  input  logic             issue_stall,
  output logic             issue_int,
  output logic [6:0]       Opcode,
  output logic [2:0]       Funct3,
  output logic [6:0]       Funct7,
  output logic [XLEN-1:0]  RS1,
  output logic [XLEN-1:0]  RS2,
  output logic [TAG_W-1:0] RD_Tag
);
  import variables::int_iq_entry_t;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  int_iq_entry_t   r_q [DEPTH];
  logic [CW-1:0]   r_count;

  int_iq_entry_t   w_woke [DEPTH];
  int_iq_entry_t   w_next [DEPTH];
  int_iq_entry_t   w_disp;
  logic            w_rdy1_n [DEPTH];
  logic            w_rdy2_n [DEPTH];
  logic [XLEN-1:0] w_val1_n [DEPTH];
  logic [XLEN-1:0] w_val2_n [DEPTH];
  logic            w_drdy1, w_drdy2;
  logic [XLEN-1:0] w_dval1, w_dval2;
  logic [DEPTH-1:0] w_rdy_vec;
  logic [SW-1:0]   w_sel;
  logic            w_any, w_do_disp;
  logic [CW-1:0]   w_disp_pos, w_count_next;

  assign dispatch_ready = (r_count < CW'(DEPTH));
  assign w_do_disp      = dispatch_valid & dispatch_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    operand_capture u_cap1 (
      .i_rdy(r_q[g].rdy1), .i_tag(r_q[g].tag1), .i_val(r_q[g].val1), .i_cdb(cdb_in),
      .o_rdy(w_rdy1_n[g]), .o_val(w_val1_n[g])
    );
    operand_capture u_cap2 (
      .i_rdy(r_q[g].rdy2), .i_tag(r_q[g].tag2), .i_val(r_q[g].val2), .i_cdb(cdb_in),
      .o_rdy(w_rdy2_n[g]), .o_val(w_val2_n[g])
    );
    // Readiness uses registered operand state only: a wakeup issues next cycle.
    assign w_rdy_vec[g] = r_q[g].valid & r_q[g].rdy1 & r_q[g].rdy2;
  end

  // Dispatch operands snoop the same broadcast so a same-cycle producer is caught.
  operand_capture u_disp_cap1 (
    .i_rdy(disp_rs1_rdy), .i_tag(disp_rs1_tag), .i_val(disp_rs1_data), .i_cdb(cdb_in),
    .o_rdy(w_drdy1), .o_val(w_dval1)
  );
  operand_capture u_disp_cap2 (
    .i_rdy(disp_rs2_rdy), .i_tag(disp_rs2_tag), .i_val(disp_rs2_data), .i_cdb(cdb_in),
    .o_rdy(w_drdy2), .o_val(w_dval2)
  );

  // Oldest-first select: scan downward so the lowest ready index wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_rdy_vec[i]) begin
        w_any = 1'b1;
        w_sel = SW'(i);
      end
    end
  end

  assign issue_int = w_any & ~issue_stall;

  always_comb begin
    Opcode = '0;
    Funct3 = '0;
    Funct7 = '0;
    RS1    = '0;
    RS2    = '0;
    RD_Tag = '0;
    if (issue_int) begin
      Opcode = r_q[w_sel].opcode;
      Funct3 = r_q[w_sel].funct3;
      Funct7 = r_q[w_sel].funct7;
      RS1    = r_q[w_sel].val1;
      RS2    = r_q[w_sel].val2;
      RD_Tag = r_q[w_sel].rd_tag;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woke[i]      = r_q[i];
      w_woke[i].rdy1 = w_rdy1_n[i];
      w_woke[i].val1 = w_val1_n[i];
      w_woke[i].rdy2 = w_rdy2_n[i];
      w_woke[i].val2 = w_val2_n[i];
    end
  end

  always_comb begin
    w_disp        = '0;
    w_disp.valid  = 1'b1;
    w_disp.opcode = disp_opcode;
    w_disp.funct3 = disp_funct3;
    w_disp.funct7 = disp_funct7;
    w_disp.rdy1   = w_drdy1;
    w_disp.tag1   = disp_rs1_tag;
    w_disp.val1   = w_dval1;
    w_disp.rdy2   = w_drdy2;
    w_disp.tag2   = disp_rs2_tag;
    w_disp.val2   = w_dval2;
    w_disp.rd_tag = disp_rd_tag;
  end

  // Next state: compact over the issued slot, append the dispatch at the new
  // tail, then let flush override validity.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_next[i] = w_woke[i];
    if (issue_int) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(w_sel)) w_next[i] = w_woke[i + 1];
      end
      w_next[DEPTH-1].valid = 1'b0;
    end
    w_disp_pos = r_count - CW'(issue_int);
    if (w_do_disp) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == w_disp_pos) w_next[i] = w_disp;
      end
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) w_next[i].valid = 1'b0;
    end
    w_count_next = flush ? '0 : (r_count + CW'(w_do_disp) - CW'(issue_int));
  end

  // Only validity and occupancy are reset; payload is don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i].valid <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_q     <= w_next;
    end
  end

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer reservation queue that feeds int_exec_unit and consumes the common data bus (CDB) that int_exec_unit drives.
- Holds dispatched integer/branch micro-ops and snoops the CDB to wake up operands waiting on a tag.
- Issues the oldest fully-ready entry to the integer execution unit, one per cycle.
- Sits between dispatch/rename and int_exec_unit, on the consumer side of cdb_bus.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAG_W, 6, tag width; must match cdb_bus.cdb_tag.
- XLEN, 32, operand and data width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries (branch recovery).
- dispatch_valid  input  1  new micro-op offered.
- dispatch_ready  output  1  queue can accept a micro-op this cycle.
- disp_opcode  input  7  opcode.
- disp_funct3  input  3  funct3.
- disp_funct7  input  7  funct7.
- disp_rs1_data  input  XLEN  RS1 value; meaningful when disp_rs1_rdy=1.
- disp_rs1_tag  input  TAG_W  RS1 producer tag; meaningful when disp_rs1_rdy=0.
- disp_rs1_rdy  input  1  RS1 value present.
- disp_rs2_data  input  XLEN  RS2 value.
- disp_rs2_tag  input  TAG_W  RS2 producer tag.
- disp_rs2_rdy  input  1  RS2 value present.
- disp_rd_tag  input  TAG_W  destination tag.
- cdb_in  input  cdb_bus  broadcast bus; only cdb_valid, cdb_tag and cdb_data are used.
- issue_stall  input  1  execution unit or CDB slot unavailable this cycle.
- issue_int  output  1  micro-op issued this cycle.
- Opcode  output  7  issued opcode.
- Funct3  output  3  issued funct3.
- Funct7  output  7  issued funct7.
- RS1  output  XLEN  issued RS1 value.
- RS2  output  XLEN  issued RS2 value.
- RD_Tag  output  TAG_W  issued destination tag.

Behaviour:
- One clock domain. Reset is asynchronous, active-low (rst_n). During reset all entries are invalid, count=0, dispatch_ready=1, issue_int=0 and all issue data outputs are 0.
- Storage is an age-ordered shifting queue: slot 0 is the oldest. Each entry holds valid, opcode, funct3, funct7, rdy1, tag1, val1, rdy2, tag2, val2 and rd_tag.
- dispatch_ready = (count < DEPTH), from registered state only. There is no same-cycle bypass when full, even if an issue occurs that cycle.
- Dispatch: when dispatch_valid and dispatch_ready, the micro-op is written at slot count at the clock edge. If an issue happens in the same cycle, it is written at count-1 after compaction.
- CDB wakeup: each cycle, every valid entry with rdyN=0 and tagN==cdb_in.cdb_tag, while cdb_in.cdb_valid=1, latches valN=cdb_data and sets rdyN=1 at the edge.
  - The same snoop applies to the incoming dispatch operands, so a producer broadcasting in the dispatch cycle is not missed.
  - cdb_branch=1 with cdb_valid=0 never wakes an operand.
- Ready entry = valid & rdy1 & rdy2. Readiness is evaluated on registered state, so an operand woken at edge N can issue in cycle N+1 at the earliest.
- Issue select: the lowest-index ready entry. Outputs are combinational from that entry.
  - issue_int = any_ready & ~issue_stall.
  - When issue_int=0, all issue data outputs are 0.
- On issue_int=1 the selected entry is removed at the edge, and entries above it shift down one slot. Wakeups apply to the shifted entries in the same cycle.
- issue_stall only gates issue. Wakeup and dispatch continue normally.
- flush: at the edge, all entries are invalid and count=0. Flush has priority over same-cycle dispatch and issue (both are discarded). issue_int is still driven combinationally in the flush cycle; the consumer ignores it.
- Reset asserted mid-operation: contents are lost immediately and outputs go to reset values asynchronously.
- Count invariant: 0 ≤ count ≤ DEPTH. Simultaneous dispatch and issue leave count unchanged.
- Tag 0 has no special meaning; rdyN alone decides operand validity.

Decomposition:
- Shared package variables.sv:
  - cdb_bus (existing).
  - New int_iq_entry_t struct.
  - TAG_W and XLEN constants.
  - Opcode constants (B_TYPE etc., existing).
- Sub-module operand_capture: a combinational per-operand snoop. Inputs are rdy, tag, val and cdb_in; outputs are the next rdy and val. It is instantiated 2×DEPTH times, plus 2 for the dispatch path.

Test Plan:
- Reset/empty: rst_n=0 then 1, no dispatch → dispatch_ready=1, issue_int=0, outputs 0.
- Ready dispatch: ADD with rs1=5, rs2=7 both ready, rd_tag=3 → next cycle issue_int=1, RS1=5, RS2=7, RD_Tag=3, Opcode=0110011; queue empty after.
- Wakeup: dispatch with rs1 tag=9 not ready, rs2=1 ready. Two cycles later CDB {valid=1, tag=9, data=0x10} → issue in the following cycle with RS1=0x10. A CDB with tag=8 causes no issue.
- Dispatch-cycle snoop: dispatch rs2 tag=4 not ready while the CDB broadcasts tag=4, data=0xAA in the same cycle → issues next cycle with RS2=0xAA.
- Age order and full:
  - Fill 4 entries: entry0 waits on tag 2, entries 1–3 are ready. dispatch_ready=0; issues occur in order 1, 2, 3 with dispatch_ready=1 after the first.
  - Wake tag 2 → entry0 issues.
- Stall and flush:
  - issue_stall=1 for 3 cycles with a ready entry → issue_int=0 and the entry is retained, then issues on release.
  - flush together with dispatch → count=0 and the dispatched op is dropped.
